// File: rtl/text_cursor_writer_if.sv
// rtl/text_cursor_writer_if.sv - byte-in / character-RAM-out bundle for the terminal writer
interface text_cursor_writer_if #(
  parameter int COL_BITS = 5,
  parameter int ROW_BITS = 2
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic                ram_we;
  logic [ROW_BITS-1:0] ram_row;
  logic [COL_BITS-1:0] ram_col;
  logic [7:0]          ram_wdata;
  logic [ROW_BITS-1:0] cursor_row;
  logic [COL_BITS-1:0] cursor_col;
  logic                overflow;
  logic                clr_ovf;

  modport slave (
    input  rx_data, rx_valid, clr_ovf,
    output rx_ready, ram_we, ram_row, ram_col, ram_wdata,
           cursor_row, cursor_col, overflow
  );

  modport master (
    output rx_data, rx_valid, clr_ovf,
    input  rx_ready, ram_we, ram_row, ram_col, ram_wdata,
           cursor_row, cursor_col, overflow
  );
endinterface

// File: rtl/text_cursor_writer.sv
// rtl/text_cursor_writer.sv - turns received bytes into character-RAM writes and tracks the cursor
module text_cursor_writer #(
  parameter int          COL_BITS  = 5,
  parameter int          ROW_BITS  = 2,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset,
  text_cursor_writer_if.slave    bus
);
  localparam int CELL_BITS = ROW_BITS + COL_BITS;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [CELL_BITS-1:0] ONE_CELL  = 1;
  localparam logic [CELL_BITS-1:0] LAST_CELL = '1;
  localparam logic [ROW_BITS-1:0]  ONE_ROW   = 1;
  localparam logic [COL_BITS-1:0]  COL_ZERO  = '0;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  // Cursor, write address and sweep index are linear cell numbers {row, col},
  // so advancing, stepping back and wrapping fall out of plain +1 / -1.
  logic [0:0]           state_q,    state_d;
  logic [CELL_BITS-1:0] cur_q,      cur_d;
  logic [CELL_BITS-1:0] sweep_q,    sweep_d;
  logic [CELL_BITS-1:0] addr_q,     addr_d;
  logic [7:0]           wdata_q,    wdata_d;
  logic                 we_q,       we_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 ovf_q,      ovf_d;

  logic                 accept;
  logic [ROW_BITS-1:0]  cur_row;

  assign accept  = bus.rx_valid && rx_ready_q;
  assign cur_row = cur_q[CELL_BITS-1:COL_BITS];

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    sweep_d    = sweep_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    rx_ready_d = rx_ready_q;
    // Set term last so a dropped byte wins over a same-cycle clear.
    ovf_d      = (ovf_q && !bus.clr_ovf) || (bus.rx_valid && !rx_ready_q);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.rx_data >= 8'h20 && bus.rx_data <= 8'h7E) begin
            we_d    = 1'b1;
            addr_d  = cur_q;
            wdata_d = bus.rx_data;
            cur_d   = cur_q + ONE_CELL;
          end else begin
            case (bus.rx_data)
              CH_CR: cur_d = {cur_row, COL_ZERO};
              CH_LF: cur_d = {cur_row + ONE_ROW, COL_ZERO};
              CH_BS: begin
                if (cur_q != '0) begin
                  we_d    = 1'b1;
                  addr_d  = cur_q - ONE_CELL;
                  wdata_d = FILL_CHAR;
                  cur_d   = cur_q - ONE_CELL;
                end
              end
              CH_FF: begin
                state_d    = ST_CLEAR;
                rx_ready_d = 1'b0;
                sweep_d    = '0;
              end
              default: ;
            endcase
          end
        end
      end

      ST_CLEAR: begin
        we_d    = 1'b1;
        addr_d  = sweep_q;
        wdata_d = FILL_CHAR;
        sweep_d = sweep_q + ONE_CELL;
        if (sweep_q == LAST_CELL) begin
          state_d    = ST_IDLE;
          rx_ready_d = 1'b1;
          cur_d      = '0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        rx_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      sweep_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rx_ready_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      sweep_q    <= sweep_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rx_ready_q <= rx_ready_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.ram_we     = we_q;
  assign bus.ram_row    = addr_q[CELL_BITS-1:COL_BITS];
  assign bus.ram_col    = addr_q[COL_BITS-1:0];
  assign bus.ram_wdata  = wdata_q;
  assign bus.cursor_row = cur_q[CELL_BITS-1:COL_BITS];
  assign bus.cursor_col = cur_q[COL_BITS-1:0];
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_text_cursor_writer.sv
// tb/tb_text_cursor_writer.sv - directed scoreboard bench for text_cursor_writer
module tb_text_cursor_writer;
  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [14:0] exp_q[$];

  text_cursor_writer_if #(.COL_BITS(5), .ROW_BITS(2)) bus ();

  text_cursor_writer #(.COL_BITS(5), .ROW_BITS(2), .FILL_CHAR(8'h20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [1:0] row, input logic [4:0] col, input logic [7:0] data);
    exp_q.push_back({row, col, data});
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic chk_cursor(input string tag, input logic [1:0] row, input logic [4:0] col);
    chk(tag, {25'd0, bus.cursor_row, bus.cursor_col}, {25'd0, row, col});
  endtask

  // Every observed write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && bus.ram_we) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_write observed=%0h expected=none",
               {bus.ram_row, bus.ram_col, bus.ram_wdata});
      end
      if (exp_q.size() != 0) begin
        logic [14:0] e;
        e = exp_q.pop_front();
        tests++;
        assert ({bus.ram_row, bus.ram_col, bus.ram_wdata} === e) else begin
          fails++;
          $error("FAIL write observed=%0h expected=%0h",
                 {bus.ram_row, bus.ram_col, bus.ram_wdata}, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.clr_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", bus.rx_ready, 1);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_wr_bus", {bus.ram_row, bus.ram_col, bus.ram_wdata}, 0);
    chk_cursor("rst_cursor", 2'd0, 5'd0);
    reset = 1'b1;

    // single printable byte
    push_wr(2'd0, 5'd0, 8'h41);
    send(8'h41);
    chk("a_we", bus.ram_we, 1);
    chk_cursor("a_cursor", 2'd0, 5'd1);
    @(posedge clk); #1;
    chk("a_we_low", bus.ram_we, 0);

    // full row 0 then cursor lands on (1,0)
    send(8'h0D);
    chk_cursor("cr_row0", 2'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      push_wr(2'd0, i[4:0], 8'h41);
      send(8'h41);
    end
    chk_cursor("row0_full", 2'd1, 5'd0);

    // backspace across a row boundary
    push_wr(2'd0, 5'd31, 8'h20);
    send(8'h08);
    chk_cursor("bs_wrap", 2'd0, 5'd31);

    send(8'h0A);
    send(8'h0A);
    send(8'h0A);
    chk_cursor("lf_to_row3", 2'd3, 5'd0);
    for (int i = 0; i < 32; i++) begin
      push_wr(2'd3, i[4:0], 8'h41);
      send(8'h41);
    end
    chk_cursor("grid_wrap", 2'd0, 5'd0);

    send(8'h08);
    chk_cursor("bs_origin", 2'd0, 5'd0);

    // CR / LF from (2,5)
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 5; i++) begin
      push_wr(2'd2, i[4:0], 8'h41 + i[7:0]);
      send(8'h41 + i[7:0]);
    end
    chk_cursor("at_2_5", 2'd2, 5'd5);
    send(8'h0D);
    chk_cursor("cr", 2'd2, 5'd0);
    send(8'h0A);
    chk_cursor("lf", 2'd3, 5'd0);
    send(8'h0A);
    chk_cursor("lf_wrap", 2'd0, 5'd0);

    // printable range edges and ignored bytes
    push_wr(2'd0, 5'd0, 8'h7E);
    send(8'h7E);
    push_wr(2'd0, 5'd1, 8'h20);
    send(8'h20);
    send(8'h1B);
    send(8'h80);
    send(8'h7F);
    send(8'h1F);
    chk_cursor("ignored", 2'd0, 5'd2);

    // clear sweep with dropped bytes, the second alongside clr_ovf
    for (int i = 0; i < 128; i++) push_wr(i[6:5], i[4:0], 8'h20);
    send(8'h0C);
    chk("ff_rx_ready_low", bus.rx_ready, 0);
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 300) begin
      bus.rx_valid = (n == 10) || (n == 20);
      bus.rx_data  = 8'h41;
      bus.clr_ovf  = (n == 20);
      @(posedge clk); #1;
      n++;
    end
    bus.rx_valid = 1'b0;
    bus.clr_ovf  = 1'b0;
    chk("sweep_len", n, 128);
    chk("ovf_set_wins", bus.overflow, 1);
    chk_cursor("sweep_cursor", 2'd0, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sweep_all_written", exp_q.size(), 0);
    chk("sweep_we_low", bus.ram_we, 0);
    bus.clr_ovf = 1'b1;
    @(posedge clk); #1;
    bus.clr_ovf = 1'b0;
    chk("ovf_cleared", bus.overflow, 0);

    // move cursor off origin, then abort a sweep with reset
    push_wr(2'd0, 5'd0, 8'h42);
    send(8'h42);
    for (int i = 0; i < 128; i++) push_wr(i[6:5], i[4:0], 8'h20);
    send(8'h0C);
    repeat (40) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    chk("abort_we", bus.ram_we, 0);
    chk("abort_rx_ready", bus.rx_ready, 1);
    chk_cursor("abort_cursor", 2'd0, 5'd0);
    chk("abort_remaining", exp_q.size(), 89);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;

    push_wr(2'd0, 5'd0, 8'h43);
    send(8'h43);
    @(posedge clk); #1;
    chk_cursor("post_abort", 2'd0, 5'd1);
    chk("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
